stage_wb: RTL

Write-back stage of the pipelined CPU; the writer end of the register-file interface that the decode stage reads.
- Holds the MEM/WB pipeline register.
- Selects the write-back value and drives the register-file write port (write enable, addr3, data3).
- Retires instructions: counts them, updates the WWD output port, and latches halt.
- Its rf_* outputs also serve as the WB-to-ID forwarding source.

---
 rtl/stage_wb_pkg.sv | 25 ++
 rtl/stage_wb_mem_wb_reg.sv | 80 ++++++++
 rtl/stage_wb.sv | 118 +++++++++++
 3 files changed

// File: rtl/stage_wb_pkg.sv
// rtl/stage_wb_pkg.sv - shared widths and write-back source select for the WB stage
package stage_wb_pkg;

  localparam int WORD_SIZE = 16;
  localparam int RF_ADDR_W = 2;
  localparam int CNT_W     = 16;

  // Write-back value source, shared with the control unit.
  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_MEM = 2'd1,
    WB_SRC_PC  = 2'd2
  } wb_src_e;

  // The link address wins over load data, which wins over the ALU result.
  function automatic wb_src_e wb_src_sel(input logic pc_to_reg, input logic mem_to_reg);
    if (pc_to_reg) begin
      return WB_SRC_PC;
    end else if (mem_to_reg) begin
      return WB_SRC_MEM;
    end
    return WB_SRC_ALU;
  endfunction

endpackage

// File: rtl/stage_wb_mem_wb_reg.sv
// rtl/stage_wb_mem_wb_reg.sv - MEM/WB pipeline register with bubble insertion
module mem_wb_reg
  import stage_wb_pkg::*;
#(
  parameter int W = WORD_SIZE,
  parameter int A = RF_ADDR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic         in_stall,
  input  logic         in_block,
  input  logic         in_rf_write,
  input  logic         in_mem_to_reg,
  input  logic         in_pc_to_reg,
  input  logic         in_halt,
  input  logic         in_wwd,
  input  logic [A-1:0] in_dest,
  input  logic [W-1:0] in_alu_result,
  input  logic [W-1:0] in_mem_data,
  input  logic [W-1:0] in_pc_plus1,
  output logic         wb_valid,
  output logic         wb_rf_write,
  output logic         wb_mem_to_reg,
  output logic         wb_pc_to_reg,
  output logic         wb_halt,
  output logic         wb_wwd,
  output logic [A-1:0] wb_dest,
  output logic [W-1:0] wb_alu,
  output logic [W-1:0] wb_mem,
  output logic [W-1:0] wb_pc1
);

  logic         valid_q, rf_write_q, mem_to_reg_q, pc_to_reg_q, halt_q, wwd_q;
  logic [A-1:0] dest_q;
  logic [W-1:0] alu_q, mem_q, pc1_q;
  logic         valid_d;

  // A stalled or blocked slot becomes a bubble; payload is captured regardless.
  assign valid_d = in_valid & ~in_stall & ~in_block;

  // Pipeline register; payload is only meaningful while valid_q is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      rf_write_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      pc_to_reg_q  <= 1'b0;
      halt_q       <= 1'b0;
      wwd_q        <= 1'b0;
      dest_q       <= '0;
      alu_q        <= '0;
      mem_q        <= '0;
      pc1_q        <= '0;
    end else begin
      valid_q      <= valid_d;
      rf_write_q   <= in_rf_write;
      mem_to_reg_q <= in_mem_to_reg;
      pc_to_reg_q  <= in_pc_to_reg;
      halt_q       <= in_halt;
      wwd_q        <= in_wwd;
      dest_q       <= in_dest;
      alu_q        <= in_alu_result;
      mem_q        <= in_mem_data;
      pc1_q        <= in_pc_plus1;
    end
  end

  assign wb_valid      = valid_q;
  assign wb_rf_write   = rf_write_q;
  assign wb_mem_to_reg = mem_to_reg_q;
  assign wb_pc_to_reg  = pc_to_reg_q;
  assign wb_halt       = halt_q;
  assign wb_wwd        = wwd_q;
  assign wb_dest       = dest_q;
  assign wb_alu        = alu_q;
  assign wb_mem        = mem_q;
  assign wb_pc1        = pc1_q;

endmodule

// File: rtl/stage_wb.sv
// rtl/stage_wb.sv - write-back stage: register-file write port, retire count, WWD and halt
module stage_wb
  import stage_wb_pkg::*;
#(
  parameter int WORD_SIZE = stage_wb_pkg::WORD_SIZE,
  parameter int RF_ADDR_W = stage_wb_pkg::RF_ADDR_W,
  parameter int CNT_W     = stage_wb_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_stall,
  input  logic                 in_rf_write,
  input  logic                 in_mem_to_reg,
  input  logic                 in_pc_to_reg,
  input  logic                 in_halt,
  input  logic                 in_wwd,
  input  logic [RF_ADDR_W-1:0] in_dest,
  input  logic [WORD_SIZE-1:0] in_alu_result,
  input  logic [WORD_SIZE-1:0] in_mem_data,
  input  logic [WORD_SIZE-1:0] in_pc_plus1,
  output logic                 rf_write,
  output logic [RF_ADDR_W-1:0] rf_addr3,
  output logic [WORD_SIZE-1:0] rf_data3,
  output logic [CNT_W-1:0]     num_inst,
  output logic [WORD_SIZE-1:0] output_port,
  output logic                 is_halted
);

  logic                 wb_valid, wb_rf_write, wb_mem_to_reg, wb_pc_to_reg, wb_halt, wb_wwd;
  logic [RF_ADDR_W-1:0] wb_dest;
  logic [WORD_SIZE-1:0] wb_alu, wb_mem, wb_pc1;
  logic                 retire, block;

  logic [CNT_W-1:0]     num_inst_q, num_inst_d;
  logic [WORD_SIZE-1:0] output_port_q, output_port_d;
  logic                 is_halted_q, is_halted_d;

  // Nothing new enters once halted, nor on the edge the HLT itself retires.
  assign block  = is_halted_q | (wb_valid & wb_halt);
  assign retire = wb_valid;

  mem_wb_reg #(
    .W(WORD_SIZE),
    .A(RF_ADDR_W)
  ) u_mem_wb_reg (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_stall     (in_stall),
    .in_block     (block),
    .in_rf_write  (in_rf_write),
    .in_mem_to_reg(in_mem_to_reg),
    .in_pc_to_reg (in_pc_to_reg),
    .in_halt      (in_halt),
    .in_wwd       (in_wwd),
    .in_dest      (in_dest),
    .in_alu_result(in_alu_result),
    .in_mem_data  (in_mem_data),
    .in_pc_plus1  (in_pc_plus1),
    .wb_valid     (wb_valid),
    .wb_rf_write  (wb_rf_write),
    .wb_mem_to_reg(wb_mem_to_reg),
    .wb_pc_to_reg (wb_pc_to_reg),
    .wb_halt      (wb_halt),
    .wb_wwd       (wb_wwd),
    .wb_dest      (wb_dest),
    .wb_alu       (wb_alu),
    .wb_mem       (wb_mem),
    .wb_pc1       (wb_pc1)
  );

  // Write port is driven purely from registered fields, so it is stable all cycle.
  always_comb begin
    rf_write = wb_valid & wb_rf_write;
    rf_addr3 = wb_dest;
    rf_data3 = wb_alu;
    case (wb_src_sel(wb_pc_to_reg, wb_mem_to_reg))
      WB_SRC_PC:  rf_data3 = wb_pc1;
      WB_SRC_MEM: rf_data3 = wb_mem;
      default:    rf_data3 = wb_alu;
    endcase
  end

  // Retire bookkeeping: count, WWD capture, sticky halt.
  always_comb begin
    num_inst_d    = num_inst_q;
    output_port_d = output_port_q;
    is_halted_d   = is_halted_q;
    if (retire) begin
      num_inst_d = num_inst_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (wb_wwd) begin
        output_port_d = wb_alu;
      end
      if (wb_halt) begin
        is_halted_d = 1'b1;
      end
    end
  end

  // Retire state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_inst_q    <= '0;
      output_port_q <= '0;
      is_halted_q   <= 1'b0;
    end else begin
      num_inst_q    <= num_inst_d;
      output_port_q <= output_port_d;
      is_halted_q   <= is_halted_d;
    end
  end

  assign num_inst    = num_inst_q;
  assign output_port = output_port_q;
  assign is_halted   = is_halted_q;

endmodule
